// File: rtl/dpsram_pkg.sv
// ============================================================================
// dpsram_pkg : shared types, default geometry and bit-merge helper for dpsram
// Rev 1.0
// ============================================================================
`default_nettype none

package dpsram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_N = 4;
  localparam int DEF_W = 256;
  localparam int DEF_M = 8;

  // Active-low enable: a 0 in bweb selects the new bit.
  function automatic logic bw_merge(input logic old_bit, input logic new_bit, input logic bweb);
    return bweb ? old_bit : new_bit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpsram_port_ctl.sv
// ============================================================================
// dpsram_port_ctl : decodes one port's active-low controls into enables/mask
// Rev 1.0
// ============================================================================
`default_nettype none

module dpsram_port_ctl
  import dpsram_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  parameter int M = DEF_M
) (
  input  logic         ready_i,
  input  logic         ceb_i,
  input  logic         web_i,
  input  logic [N-1:0] bweb_i,
  input  logic [M-1:0] addr_i,
  output logic         acc_o,
  output logic         rd_en_o,
  output logic [N-1:0] wr_mask_o,
  output logic         addr_ok_o,
  output logic         err_o
);

  assign addr_ok_o = ({1'b0, addr_i} < W[M:0]);
  assign acc_o     = ready_i & ~ceb_i;
  assign rd_en_o   = acc_o & web_i;
  // Out-of-range writes are dropped entirely, so the mask is forced empty.
  assign wr_mask_o = (acc_o & ~web_i & addr_ok_o) ? ~bweb_i : '0;
  assign err_o     = acc_o & ~addr_ok_o;

endmodule

`default_nettype wire

// File: rtl/dpsram_rtl_model.sv
// ============================================================================
// dpsram_rtl_model : 256x4 dual-port SRAM responder with clear FSM and flags
// Rev 1.0
// ============================================================================
`default_nettype none

module dpsram_rtl_model
  import dpsram_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] AA,
  input  logic [M-1:0] AB,
  input  logic [N-1:0] DA,
  input  logic [N-1:0] DB,
  input  logic [N-1:0] BWEBA,
  input  logic [N-1:0] BWEBB,
  input  logic         WEBA,
  input  logic         WEBB,
  input  logic         CEBA,
  input  logic         CEBB,
  output logic [N-1:0] QA,
  output logic [N-1:0] QB,
  output logic         init_done,
  output logic         collision,
  output logic         addr_err
);

  localparam logic [M-1:0] LAST = M'(W - 1);

  state_e       state_q;
  logic [M-1:0] cnt_q;
  logic [N-1:0] qa_q, qb_q;
  logic         init_done_q, collision_q, addr_err_q;
  logic [N-1:0] mem_q [W];

  logic         acc_a, rd_en_a, addr_ok_a, err_a;
  logic         acc_b, rd_en_b, addr_ok_b, err_b;
  logic [N-1:0] wr_mask_a, wr_mask_b;
  logic [N-1:0] base_a, mem_a_d, mem_b_d;
  logic         collide;

  dpsram_port_ctl #(.N(N), .W(W), .M(M)) u_ctl_a (
    .ready_i   (state_q == ST_READY),
    .ceb_i     (CEBA),
    .web_i     (WEBA),
    .bweb_i    (BWEBA),
    .addr_i    (AA),
    .acc_o     (acc_a),
    .rd_en_o   (rd_en_a),
    .wr_mask_o (wr_mask_a),
    .addr_ok_o (addr_ok_a),
    .err_o     (err_a)
  );

  dpsram_port_ctl #(.N(N), .W(W), .M(M)) u_ctl_b (
    .ready_i   (state_q == ST_READY),
    .ceb_i     (CEBB),
    .web_i     (WEBB),
    .bweb_i    (BWEBB),
    .addr_i    (AB),
    .acc_o     (acc_b),
    .rd_en_o   (rd_en_b),
    .wr_mask_o (wr_mask_b),
    .addr_ok_o (addr_ok_b),
    .err_o     (err_b)
  );

  assign collide = acc_a & acc_b & addr_ok_a & (AA == AB) & (~WEBA | ~WEBB);

  // Port A's word is layered on top of port B's when both write one address,
  // so A wins overlapping bits while disjoint bits from each port survive.
  always_comb begin
    mem_b_d = '0;
    mem_a_d = '0;
    for (int i = 0; i < N; i++) begin
      mem_b_d[i] = bw_merge(mem_q[AB][i], DB[i], ~wr_mask_b[i]);
    end
    base_a = ((|wr_mask_b) && (AA == AB)) ? mem_b_d : mem_q[AA];
    for (int i = 0; i < N; i++) begin
      mem_a_d[i] = bw_merge(base_a[i], DA[i], ~wr_mask_a[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (|wr_mask_b) mem_q[AB] <= mem_b_d;
      if (|wr_mask_a) mem_q[AA] <= mem_a_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      qa_q        <= '0;
      qb_q        <= '0;
      init_done_q <= 1'b0;
      collision_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + M'(1);
          if (cnt_q == LAST) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (rd_en_a) qa_q <= addr_ok_a ? mem_q[AA] : '0;
          if (rd_en_b) qb_q <= addr_ok_b ? mem_q[AB] : '0;
          if (collide) collision_q <= 1'b1;
          if (err_a | err_b) addr_err_q <= 1'b1;
        end
      endcase
    end
  end

  assign QA        = qa_q;
  assign QB        = qb_q;
  assign init_done = init_done_q;
  assign collision = collision_q;
  assign addr_err  = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dpsram_rtl_model.sv
// ============================================================================
// tb_dpsram_rtl_model : randomized self-checking bench against a word-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dpsram_rtl_model;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] aa, ab;
  logic [3:0] da, db, bweba, bwebb;
  logic       weba, webb, ceba, cebb;
  logic [3:0] qa, qb;
  logic       init_done, collision, addr_err;

  logic [7:0] aa2, ab2;
  logic [3:0] da2, db2, bweba2, bwebb2;
  logic       weba2, webb2, ceba2, cebb2;
  logic [3:0] qa2, qb2;
  logic       init_done2, collision2, addr_err2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] ref_mem [256];
  int         edge_cnt;
  logic [3:0] exp_qa, exp_qb;
  logic       exp_init, exp_col, exp_err;

  dpsram_rtl_model dut (
    .clk(clk), .rst_n(rst_n), .AA(aa), .AB(ab), .DA(da), .DB(db),
    .BWEBA(bweba), .BWEBB(bwebb), .WEBA(weba), .WEBB(webb), .CEBA(ceba), .CEBB(cebb),
    .QA(qa), .QB(qb), .init_done(init_done), .collision(collision), .addr_err(addr_err)
  );

  dpsram_rtl_model #(.N(4), .W(200), .M(8)) dut_w200 (
    .clk(clk), .rst_n(rst_n), .AA(aa2), .AB(ab2), .DA(da2), .DB(db2),
    .BWEBA(bweba2), .BWEBB(bwebb2), .WEBA(weba2), .WEBB(webb2), .CEBA(ceba2), .CEBB(cebb2),
    .QA(qa2), .QB(qb2), .init_done(init_done2), .collision(collision2), .addr_err(addr_err2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (got hang, expected finish)");
    $fatal(1);
  end

  task automatic model_reset;
    for (int i = 0; i < 256; i++) ref_mem[i] = 4'h0;
    edge_cnt = 0;
    exp_qa = 4'h0; exp_qb = 4'h0;
    exp_init = 1'b0; exp_col = 1'b0; exp_err = 1'b0;
  endtask

  // Drive both ports for one edge of the main instance and advance the model.
  task automatic step(input logic ca, input logic wa, input logic [7:0] a_addr,
                      input logic [3:0] a_d, input logic [3:0] a_bw,
                      input logic cb, input logic wb, input logic [7:0] b_addr,
                      input logic [3:0] b_d, input logic [3:0] b_bw);
    ceba = ca; weba = wa; aa = a_addr; da = a_d; bweba = a_bw;
    cebb = cb; webb = wb; ab = b_addr; db = b_d; bwebb = b_bw;
    @(posedge clk);
    if (edge_cnt < 256) begin
      edge_cnt++;
      if (edge_cnt == 256) exp_init = 1'b1;
    end else begin
      if (!ca && wa) exp_qa = ref_mem[a_addr];
      if (!cb && wb) exp_qb = ref_mem[b_addr];
      if (!ca && !cb && a_addr == b_addr && (!wa || !wb)) exp_col = 1'b1;
      if (!cb && !wb)
        for (int i = 0; i < 4; i++) if (!b_bw[i]) ref_mem[b_addr][i] = b_d[i];
      if (!ca && !wa)
        for (int i = 0; i < 4; i++) if (!a_bw[i]) ref_mem[a_addr][i] = a_d[i];
    end
    #1;
  endtask

  task automatic idle;
    step(1'b1, 1'b1, 8'h00, 4'h0, 4'hF, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
  endtask

  task automatic test_reset;
    ceba2 = 1'b1; weba2 = 1'b1; aa2 = 8'h00; da2 = 4'h0; bweba2 = 4'hF;
    cebb2 = 1'b1; webb2 = 1'b1; ab2 = 8'h00; db2 = 4'h0; bwebb2 = 4'hF;
    ceba  = 1'b1; cebb  = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (qa !== exp_qa) $display("FAIL reset_qa: got %h expected %h", qa, exp_qa); else n_pass++;
    n_checks++; if (qb !== exp_qb) $display("FAIL reset_qb: got %h expected %h", qb, exp_qb); else n_pass++;
    n_checks++; if (init_done !== exp_init) $display("FAIL reset_init: got %b expected %b", init_done, exp_init); else n_pass++;
    n_checks++; if (collision !== exp_col) $display("FAIL reset_col: got %b expected %b", collision, exp_col); else n_pass++;
    n_checks++; if (addr_err !== exp_err) $display("FAIL reset_err: got %b expected %b", addr_err, exp_err); else n_pass++;
    n_checks++; if (init_done2 !== 1'b0) $display("FAIL reset_init_w200: got %b expected 0", init_done2); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_clear(input logic poke);
    for (int i = 1; i <= 256; i++) begin
      if (poke && i == 10) step(1'b0, 1'b0, 8'd3, 4'h7, 4'h0, 1'b0, 1'b1, 8'd3, 4'h0, 4'hF);
      else idle();
      n_checks++;
      if (init_done !== exp_init) $display("FAIL clear_init edge %0d: got %b expected %b", i, init_done, exp_init); else n_pass++;
      n_checks++;
      if (qa !== exp_qa) $display("FAIL clear_qa edge %0d: got %h expected %h", i, qa, exp_qa); else n_pass++;
    end
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 8'(i), 4'h0, 4'hF, 1'b0, 1'b1, 8'(255 - i), 4'h0, 4'hF);
      n_checks++; if (qa !== exp_qa) $display("FAIL sweep_qa addr %0d: got %h expected %h", i, qa, exp_qa); else n_pass++;
      n_checks++; if (qb !== exp_qb) $display("FAIL sweep_qb addr %0d: got %h expected %h", 255 - i, qb, exp_qb); else n_pass++;
    end
    n_checks++; if (collision !== exp_col) $display("FAIL sweep_col: got %b expected %b", collision, exp_col); else n_pass++;
    n_checks++; if (addr_err !== exp_err) $display("FAIL sweep_err: got %b expected %b", addr_err, exp_err); else n_pass++;
  endtask

  task automatic test_seq_write;
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 8'(2 + k), 4'(1 + k), 4'h0, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 8'(2 + k), 4'h0, 4'hF, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
      n_checks++; if (qa !== 4'(1 + k)) $display("FAIL seq_read_a addr %0d: got %h expected %h", 2 + k, qa, 4'(1 + k)); else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 8'h00, 4'h0, 4'hF, 1'b0, 1'b1, 8'(2 + k), 4'h0, 4'hF);
      n_checks++; if (qb !== 4'(1 + k)) $display("FAIL seq_read_b addr %0d: got %h expected %h", 2 + k, qb, 4'(1 + k)); else n_pass++;
      n_checks++; if (qa !== exp_qa) $display("FAIL seq_hold_a: got %h expected %h", qa, exp_qa); else n_pass++;
    end
  endtask

  task automatic test_partial;
    step(1'b0, 1'b0, 8'd7, 4'hF, 4'h0, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
    step(1'b0, 1'b0, 8'd7, 4'h0, 4'b1010, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
    n_checks++; if (qa !== exp_qa) $display("FAIL partial_no_writethrough: got %h expected %h", qa, exp_qa); else n_pass++;
    step(1'b0, 1'b1, 8'd7, 4'h0, 4'hF, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
    n_checks++; if (qa !== 4'hA) $display("FAIL partial_read: got %h expected a", qa); else n_pass++;
  endtask

  task automatic test_collision;
    step(1'b1, 1'b1, 8'h00, 4'h0, 4'hF, 1'b0, 1'b0, 8'd9, 4'hC, 4'h0);
    n_checks++; if (collision !== 1'b0) $display("FAIL col_pre: got %b expected 0", collision); else n_pass++;
    step(1'b0, 1'b0, 8'd9, 4'h3, 4'h0, 1'b0, 1'b1, 8'd9, 4'h0, 4'hF);
    n_checks++; if (qb !== 4'hC) $display("FAIL col_rbw_qb: got %h expected c", qb); else n_pass++;
    n_checks++; if (collision !== 1'b1) $display("FAIL col_flag: got %b expected 1", collision); else n_pass++;
    step(1'b1, 1'b1, 8'h00, 4'h0, 4'hF, 1'b0, 1'b1, 8'd9, 4'h0, 4'hF);
    n_checks++; if (qb !== 4'h3) $display("FAIL col_after_qb: got %h expected 3", qb); else n_pass++;
    step(1'b0, 1'b0, 8'd10, 4'h5, 4'h0, 1'b0, 1'b0, 8'd10, 4'hA, 4'h0);
    step(1'b0, 1'b1, 8'd10, 4'h0, 4'hF, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
    n_checks++; if (qa !== 4'h5) $display("FAIL col_both_write: got %h expected 5", qa); else n_pass++;
    // Disjoint masks: A owns bits 1:0, B owns bits 3:2.
    step(1'b0, 1'b0, 8'd11, 4'hF, 4'b1100, 1'b0, 1'b0, 8'd11, 4'hF, 4'b0011);
    step(1'b1, 1'b1, 8'h00, 4'h0, 4'hF, 1'b0, 1'b1, 8'd11, 4'h0, 4'hF);
    n_checks++; if (qb !== exp_qb) $display("FAIL col_disjoint: got %h expected %h", qb, exp_qb); else n_pass++;
  endtask

  task automatic test_reset_midop;
    for (int k = 0; k < 10; k++)
      step(1'b0, 1'b0, 8'(k), 4'(k + 1), 4'h0, 1'b1, 1'b1, 8'h00, 4'h0, 4'hF);
    step(1'b0, 1'b1, 8'd9, 4'h0, 4'hF, 1'b0, 1'b1, 8'd4, 4'h0, 4'hF);
    n_checks++; if (qa !== 4'hA) $display("FAIL midop_pre_qa: got %h expected a", qa); else n_pass++;
    n_checks++; if (qb !== exp_qb) $display("FAIL midop_pre_qb: got %h expected %h", qb, exp_qb); else n_pass++;
    test_reset();
    test_clear(1'b0);
    test_sweep();
  endtask

  task automatic test_random;
    logic       ca, wa, cb, wb;
    logic [7:0] a_addr, b_addr;
    for (int n = 0; n < 400; n++) begin
      ca = ($urandom_range(0, 3) == 0);
      cb = ($urandom_range(0, 3) == 0);
      wa = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      a_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      b_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      step(ca, wa, a_addr, 4'($urandom), 4'($urandom), cb, wb, b_addr, 4'($urandom), 4'($urandom));
      n_checks++; if (qa !== exp_qa) $display("FAIL rand_qa iter %0d: got %h expected %h", n, qa, exp_qa); else n_pass++;
      n_checks++; if (qb !== exp_qb) $display("FAIL rand_qb iter %0d: got %h expected %h", n, qb, exp_qb); else n_pass++;
      n_checks++; if (collision !== exp_col) $display("FAIL rand_col iter %0d: got %b expected %b", n, collision, exp_col); else n_pass++;
      n_checks++; if (addr_err !== exp_err) $display("FAIL rand_err iter %0d: got %b expected %b", n, addr_err, exp_err); else n_pass++;
    end
  endtask

  task automatic test_addr_err;
    int budget;
    budget = 0;
    ceba = 1'b1; cebb = 1'b1;
    while (init_done2 !== 1'b1 && budget < 400) begin
      @(posedge clk);
      #1;
      budget++;
    end
    n_checks++; if (init_done2 !== 1'b1) $display("FAIL w200_init_timeout: got %b expected 1", init_done2); else n_pass++;
    n_checks++; if (addr_err2 !== 1'b0) $display("FAIL w200_err_pre: got %b expected 0", addr_err2); else n_pass++;
    ceba2 = 1'b0; weba2 = 1'b0; aa2 = 8'd5; da2 = 4'h9; bweba2 = 4'h0;
    @(posedge clk); #1;
    weba2 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (qa2 !== 4'h9) $display("FAIL w200_read5: got %h expected 9", qa2); else n_pass++;
    aa2 = 8'd210;
    @(posedge clk); #1;
    n_checks++; if (qa2 !== 4'h0) $display("FAIL w200_read210: got %h expected 0", qa2); else n_pass++;
    n_checks++; if (addr_err2 !== 1'b1) $display("FAIL w200_err: got %b expected 1", addr_err2); else n_pass++;
    n_checks++; if (collision2 !== 1'b0) $display("FAIL w200_col: got %b expected 0", collision2); else n_pass++;
    n_checks++; if (qb2 !== 4'h0) $display("FAIL w200_qb: got %h expected 0", qb2); else n_pass++;
    ceba2 = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_clear(1'b1);
    test_sweep();
    test_seq_write();
    test_partial();
    test_collision();
    test_reset_midop();
    test_random();
    test_addr_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
